sram_write_sequencer: RTL and testbench

Upstream stage of the column decoder. Accepts one 32-bit write request with a per-half mask, then sequences array timing: precharge, drive of the low half-word, then drive of the high half-word, then recovery. It drives BL[15:0] and ADR, which the column decoder expands into 32 bit-line enables. All timing counts are parameterised and all outputs are registered.

---
 rtl/sram_write_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_sram_write_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sram_write_sequencer
// Description : Sequences one masked 32-bit SRAM write into array timing:
//               precharge, low half-word drive, gap, high half-word drive,
//               recovery. Drives BL/ADR toward the column decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_write_sequencer #(
    parameter int PRECH_CYC = 2,
    parameter int DRIVE_CYC = 3,
    parameter int RECOV_CYC = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_data,
    input  logic [1:0]  req_mask,
    output logic        PRE,
    output logic [15:0] BL,
    output logic        ADR,
    output logic        busy,
    output logic        done
);

    localparam int c_max_cyc = (PRECH_CYC > DRIVE_CYC)
                             ? ((PRECH_CYC > RECOV_CYC) ? PRECH_CYC : RECOV_CYC)
                             : ((DRIVE_CYC > RECOV_CYC) ? DRIVE_CYC : RECOV_CYC);
    localparam int c_cnt_w   = $clog2(c_max_cyc + 1);

    localparam logic [c_cnt_w-1:0] c_prech_ld = c_cnt_w'(PRECH_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_drive_ld = c_cnt_w'(DRIVE_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_recov_ld = c_cnt_w'(RECOV_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_zero = '0;
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRECH    = 3'd1,
        DRIVE_LO = 3'd2,
        GAP      = 3'd3,
        DRIVE_HI = 3'd4,
        RECOV    = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic [31:0]          r_data;
    logic [1:0]           r_mask;
    logic                 w_accept;
    logic                 w_done_nxt;

    assign req_ready = (r_state == IDLE) && !rst;
    assign w_accept  = req_valid && req_ready;

    // State, timing counter and latched request; masked-off halves are zeroed
    // at capture so they can never reach the bit lines.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_data  <= '0;
            r_mask  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_data <= req_data & {{16{req_mask[1]}}, {16{req_mask[0]}}};
                r_mask <= req_mask;
            end
        end
    end

    // Next-state and counter reload; the counter holds remaining cycles minus one.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (req_mask == 2'b00) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = PRECH;
                        w_cnt_nxt   = c_prech_ld;
                    end
                end
            end
            PRECH: begin
                if (r_cnt == c_cnt_zero) begin
                    if (r_mask[0]) begin
                        w_state_nxt = DRIVE_LO;
                        w_cnt_nxt   = c_drive_ld;
                    end else begin
                        w_state_nxt = GAP;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - c_cnt_one;
                end
            end
            DRIVE_LO: begin
                if (r_cnt == c_cnt_zero) begin
                    if (r_mask[1]) begin
                        w_state_nxt = GAP;
                    end else begin
                        w_state_nxt = RECOV;
                        w_cnt_nxt   = c_recov_ld;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - c_cnt_one;
                end
            end
            GAP: begin
                w_state_nxt = DRIVE_HI;
                w_cnt_nxt   = c_drive_ld;
            end
            DRIVE_HI: begin
                if (r_cnt == c_cnt_zero) begin
                    w_state_nxt = RECOV;
                    w_cnt_nxt   = c_recov_ld;
                end else begin
                    w_cnt_nxt = r_cnt - c_cnt_one;
                end
            end
            RECOV: begin
                if (r_cnt == c_cnt_zero) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - c_cnt_one;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Registered outputs decoded from the upcoming state; ADR is held through
    // recovery so it only moves while the bit lines are quiet.
    always_ff @(posedge clk) begin
        if (rst) begin
            PRE  <= 1'b0;
            BL   <= '0;
            ADR  <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            PRE  <= (w_state_nxt == PRECH);
            busy <= (w_state_nxt != IDLE);
            done <= w_done_nxt;
            case (w_state_nxt)
                DRIVE_LO: begin
                    BL  <= r_data[15:0];
                    ADR <= 1'b0;
                end
                GAP: begin
                    BL  <= '0;
                    ADR <= 1'b1;
                end
                DRIVE_HI: begin
                    BL  <= r_data[31:16];
                    ADR <= 1'b1;
                end
                RECOV: begin
                    BL  <= '0;
                    ADR <= ADR;
                end
                default: begin
                    BL  <= '0;
                    ADR <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_write_sequencer
// Description : Self-checking bench for sram_write_sequencer. Two instances
//               (default timing and PRECH=1/DRIVE=1/RECOV=4) are compared
//               cycle by cycle against an expected trace built from the
//               request's mask and timing parameters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_write_sequencer;

    typedef struct packed {
        logic        pre;
        logic [15:0] bl;
        logic        adr;
        logic        busy;
        logic        done;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld [2];
    logic [31:0] dat [2];
    logic [1:0]  msk [2];
    logic        rdy [2];
    logic        pre [2];
    logic [15:0] bl  [2];
    logic        adr [2];
    logic        bsy [2];
    logic        dne [2];

    int   n_checks = 0;
    int   n_errors = 0;
    int   p_cyc [2] = '{2, 1};
    int   d_cyc [2] = '{3, 1};
    int   r_cyc [2] = '{1, 4};
    exp_t exq [$];
    bit   mon_en = 1'b0;
    logic prev_adr [2] = '{1'b0, 1'b0};

    always #5 clk = ~clk;

    sram_write_sequencer u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (vld[0]),
        .req_ready (rdy[0]),
        .req_data  (dat[0]),
        .req_mask  (msk[0]),
        .PRE       (pre[0]),
        .BL        (bl[0]),
        .ADR       (adr[0]),
        .busy      (bsy[0]),
        .done      (dne[0])
    );

    sram_write_sequencer #(
        .PRECH_CYC (1),
        .DRIVE_CYC (1),
        .RECOV_CYC (4)
    ) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (vld[1]),
        .req_ready (rdy[1]),
        .req_data  (dat[1]),
        .req_mask  (msk[1]),
        .PRE       (pre[1]),
        .BL        (bl[1]),
        .ADR       (adr[1]),
        .busy      (bsy[1]),
        .done      (dne[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic p, input logic [15:0] b, input logic a,
                                input logic bz, input logic d);
        exp_t e;
        e.pre  = p;
        e.bl   = b;
        e.adr  = a;
        e.busy = bz;
        e.done = d;
        return e;
    endfunction

    // Expected per-cycle trace (cycles 1..N after the accepting edge).
    task automatic build(input int k, input logic [31:0] d, input logic [1:0] m);
        exq.delete();
        if (m != 2'b00) begin
            for (int i = 0; i < p_cyc[k]; i++) exq.push_back(mk(1'b1, 16'h0, 1'b0, 1'b1, 1'b0));
            if (m[0])
                for (int i = 0; i < d_cyc[k]; i++) exq.push_back(mk(1'b0, d[15:0], 1'b0, 1'b1, 1'b0));
            if (m[1]) begin
                exq.push_back(mk(1'b0, 16'h0, 1'b1, 1'b1, 1'b0));
                for (int i = 0; i < d_cyc[k]; i++) exq.push_back(mk(1'b0, d[31:16], 1'b1, 1'b1, 1'b0));
            end
            for (int i = 0; i < r_cyc[k]; i++) exq.push_back(mk(1'b0, 16'h0, m[1], 1'b1, 1'b0));
        end
        exq.push_back(mk(1'b0, 16'h0, 1'b0, 1'b0, 1'b1));
    endtask

    task automatic check_cycle(input int k, input exp_t e, input string tag);
        check({tag, ".PRE"},  32'(pre[k]), 32'(e.pre));
        check({tag, ".BL"},   32'(bl[k]),  32'(e.bl));
        check({tag, ".ADR"},  32'(adr[k]), 32'(e.adr));
        check({tag, ".busy"}, 32'(bsy[k]), 32'(e.busy));
        check({tag, ".done"}, 32'(dne[k]), 32'(e.done));
        check({tag, ".ready"}, 32'(rdy[k]), 32'(!e.busy && !rst));
    endtask

    task automatic idle(input int k, input int cycles);
        vld[k] = 1'b0;
        repeat (cycles) begin
            @(posedge clk); #1;
            check_cycle(k, mk(1'b0, 16'h0, 1'b0, 1'b0, 1'b0), "idle");
        end
    endtask

    // Issues one request and checks the whole trace; returns in the done cycle
    // with req_valid low so the caller may chain a back-to-back request.
    task automatic run_req(input int k, input logic [31:0] d, input logic [1:0] m,
                           input bit hold, input int abort_at);
        int len;
        check("ready_before_req", 32'(rdy[k]), 32'd1);
        vld[k] = 1'b1;
        dat[k] = d;
        msk[k] = m;
        build(k, d, m);
        len = exq.size();
        @(posedge clk); #1;
        for (int n = 1; n <= len; n++) begin
            if (hold && n < len) begin
                vld[k] = 1'b1;
                dat[k] = $urandom;
                msk[k] = 2'($urandom_range(0, 3));
            end else begin
                vld[k] = 1'b0;
            end
            check_cycle(k, exq[n-1], $sformatf("dut%0d.m%0b.c%0d", k, m, n));
            if (n == abort_at) begin
                vld[k] = 1'b0;
                rst = 1'b1;
                @(posedge clk); #1;
                check_cycle(k, mk(1'b0, 16'h0, 1'b0, 1'b0, 1'b0), "abort_rst");
                rst = 1'b0;
                @(posedge clk); #1;
                check_cycle(k, mk(1'b0, 16'h0, 1'b0, 1'b0, 1'b0), "abort_after");
                return;
            end
            if (n < len) begin
                @(posedge clk); #1;
            end
        end
    endtask

    // Protocol invariants observed on every cycle of both instances.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < 2; k++) begin
                check("inv_pre_and_bl", 32'(pre[k] && (bl[k] != 16'h0)), 32'd0);
                if (adr[k] != prev_adr[k]) check("inv_adr_moves_bl_quiet", 32'(bl[k]), 32'd0);
                prev_adr[k] <= adr[k];
            end
        end
    end

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            vld[k] = 1'b0;
            dat[k] = '0;
            msk[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) check_cycle(k, mk(1'b0, 16'h0, 1'b0, 1'b0, 1'b0), "reset");
        rst = 1'b0;
        mon_en = 1'b1;
        idle(0, 2);

        run_req(0, 32'hA5A5_3C3C, 2'b11, 1'b0, 0);
        idle(0, 1);
        run_req(0, 32'hFFFF_0001, 2'b01, 1'b0, 0);
        idle(0, 1);
        run_req(0, 32'h8000_FFFF, 2'b10, 1'b0, 0);
        idle(0, 1);
        run_req(0, 32'h1234_5678, 2'b00, 1'b0, 0);
        idle(0, 1);
        run_req(0, 32'hDEAD_BEEF, 2'b11, 1'b1, 0);
        run_req(0, 32'h0BAD_F00D, 2'b11, 1'b0, 0);
        idle(0, 2);
        run_req(0, 32'hCAFE_F00D, 2'b11, 1'b0, 4);
        run_req(0, 32'hA5A5_3C3C, 2'b11, 1'b0, 0);
        idle(0, 1);

        idle(1, 1);
        run_req(1, 32'h1234_ABCD, 2'b11, 1'b0, 0);
        idle(1, 1);

        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 30; i++) begin
                run_req(k, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0);
                if ($urandom_range(0, 1) == 1) idle(k, $urandom_range(1, 2));
            end
            idle(k, 1);
        end

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
